// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;
   localparam int          DEF_ADDR_W   = 32;
   localparam int          DEF_DATA_W   = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          DEF_PC_STEP  = 4;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} fetch_state_e;
   typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_REDIR} pc_sel_e;
endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select: hold, sequential step, or word-aligned redirect target.
module fetch_pc_next
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int PC_STEP = DEF_PC_STEP
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  pc_sel_e           sel,
   output logic [ADDR_W-1:0] pc_next
);
   always_comb begin
      pc_next = pc;
      unique case (sel)
         PC_INC:   pc_next = pc + ADDR_W'(PC_STEP);
         PC_REDIR: pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
         default:  pc_next = pc;
      endcase
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues instruction reads, and holds each
// fetched word for decode over valid/ready; redirects flush any pending fetch.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
   parameter int                PC_STEP  = DEF_PC_STEP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_run,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_mem_read_enable,
   output logic [ADDR_W-1:0] o_mem_address,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic              i_mem_ready,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_instruction,
   output logic [ADDR_W-1:0] o_pc
);
   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_nxt;
   pc_sel_e           pc_sel;

   // Redirect outranks a completing read, so returned data is simply dropped.
   always_comb begin
      pc_sel = PC_HOLD;
      if (i_redirect)
         pc_sel = PC_REDIR;
      else if (state_q == FETCH && i_mem_ready)
         pc_sel = PC_INC;
   end

   fetch_pc_next #(.ADDR_W(ADDR_W), .PC_STEP(PC_STEP)) u_pc_next (
      .pc          (pc_q),
      .redirect_pc (i_redirect_pc),
      .sel         (pc_sel),
      .pc_next     (pc_nxt)
   );

   assign o_mem_read_enable = (state_q == FETCH);
   assign o_mem_address     = pc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         o_valid       <= 1'b0;
         o_instruction <= '0;
         o_pc          <= RESET_PC;
      end else begin
         pc_q <= pc_nxt;
         if (i_redirect) begin
            // A HOLD transfer in this same cycle has already been taken by decode.
            o_valid <= 1'b0;
            state_q <= FLUSH;
         end else begin
            unique case (state_q)
               IDLE:
                  if (i_run) state_q <= FETCH;
               FETCH:
                  if (i_mem_ready) begin
                     o_instruction <= i_mem_data;
                     o_pc          <= pc_q;
                     o_valid       <= 1'b1;
                     state_q       <= HOLD;
                  end
               HOLD:
                  if (i_ready) begin
                     o_valid <= 1'b0;
                     state_q <= i_run ? FETCH : IDLE;
                  end
               FLUSH:
                  state_q <= i_run ? FETCH : IDLE;
               default:
                  state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected (pc, word) pairs are queued as
// stimulus is set up and popped on every decode handshake.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_run = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_mem_read_enable;
   logic [31:0] o_mem_address;
   logic [31:0] i_mem_data = '0;
   logic        i_mem_ready = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .i_run             (i_run),
      .i_redirect        (i_redirect),
      .i_redirect_pc     (i_redirect_pc),
      .o_mem_read_enable (o_mem_read_enable),
      .o_mem_address     (o_mem_address),
      .i_mem_data        (i_mem_data),
      .i_mem_ready       (i_mem_ready),
      .o_valid           (o_valid),
      .i_ready           (i_ready),
      .o_instruction     (o_instruction),
      .o_pc              (o_pc)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        sb[$];
   int unsigned del_cyc[$];
   int          delivered = 0;
   int unsigned cyc = 0;
   int          mem_lat = 1;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] pc);
      exp_t e;
      e.pc  = pc;
      e.ins = mem_word(pc);
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_deliv(input int n, input int budget);
      int k;
      k = 0;
      while (delivered < n && k < budget) begin
         step();
         k++;
      end
      if (delivered < n) chk("deliver_timeout", 64'(delivered), 64'(n));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction memory: ready on the mem_lat-th consecutive strobe cycle.
   initial begin
      int cnt;
      cnt = 1;
      forever begin
         @(posedge clk);
         #1;
         i_mem_data = mem_word(o_mem_address);
         if (o_mem_read_enable) begin
            i_mem_ready = (cnt >= mem_lat);
            cnt = i_mem_ready ? 1 : cnt + 1;
         end else begin
            i_mem_ready = 1'b0;
            cnt = 1;
         end
      end
   end

   // Decode-side monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && o_valid && i_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_pc", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("sb_pc", 64'(o_pc), 64'(e.pc));
               chk("sb_ins", 64'(o_instruction), 64'(e.ins));
            end
            delivered++;
            del_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      // Reset values
      #2;
      chk("rst_strobe", 64'(o_mem_read_enable), 64'd0);
      chk("rst_addr", 64'(o_mem_address), 64'h0);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_pc", 64'(o_pc), 64'h0);
      chk("rst_ins", 64'(o_instruction), 64'h0);

      // Back-to-back zero-wait fetches
      expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8); expect_fetch(32'hC);
      step();
      reset = 1'b1; i_run = 1'b1; i_ready = 1'b1;
      wait_deliv(3, 40);
      i_run = 1'b0;
      wait_deliv(4, 20);
      for (int i = 0; i < 3; i++)
         if (del_cyc.size() > i + 1)
            chk("t1_gap", 64'(del_cyc[i+1] - del_cyc[i]), 64'd2);
      step();
      chk("t1_idle_strobe", 64'(o_mem_read_enable), 64'd0);
      chk("t1_idle_addr", 64'(o_mem_address), 64'h10);

      // Three-cycle memory wait, run dropped mid-request
      mem_lat = 3;
      expect_fetch(32'h10);
      i_run = 1'b1;
      step();
      chk("t2_strobe1", 64'(o_mem_read_enable), 64'd1);
      chk("t2_addr1", 64'(o_mem_address), 64'h10);
      i_run = 1'b0;
      step();
      chk("t2_strobe2", 64'(o_mem_read_enable), 64'd1);
      chk("t2_addr2", 64'(o_mem_address), 64'h10);
      step();
      chk("t2_strobe3", 64'(o_mem_read_enable), 64'd1);
      chk("t2_valid3", 64'(o_valid), 64'd0);
      step();
      chk("t2_strobe4", 64'(o_mem_read_enable), 64'd0);
      chk("t2_valid4", 64'(o_valid), 64'd1);
      chk("t2_pc4", 64'(o_pc), 64'h10);
      step();
      chk("t2_valid5", 64'(o_valid), 64'd0);
      chk("t2_addr5", 64'(o_mem_address), 64'h14);
      chk("t2_count", 64'(delivered), 64'd5);

      // Decode stall in HOLD
      mem_lat = 1;
      i_ready = 1'b0;
      expect_fetch(32'h14); expect_fetch(32'h18);
      i_run = 1'b1;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t3_valid", 64'(o_valid), 64'd1);
         chk("t3_pc", 64'(o_pc), 64'h14);
         chk("t3_ins", 64'(o_instruction), 64'(mem_word(32'h14)));
         chk("t3_strobe", 64'(o_mem_read_enable), 64'd0);
         if (i < 4) step();
      end
      i_ready = 1'b1;
      step();
      chk("t3_next_strobe", 64'(o_mem_read_enable), 64'd1);
      chk("t3_next_addr", 64'(o_mem_address), 64'h18);
      i_run = 1'b0;
      step();
      step();
      chk("t3_idle_valid", 64'(o_valid), 64'd0);
      chk("t3_count", 64'(delivered), 64'd7);

      // Redirect colliding with memory ready in FETCH
      expect_fetch(32'h100);
      i_run = 1'b1;
      step();
      chk("t4_fetch_addr", 64'(o_mem_address), 64'h1C);
      i_redirect = 1'b1; i_redirect_pc = 32'h103;
      step();
      i_redirect = 1'b0;
      chk("t4_flush_strobe", 64'(o_mem_read_enable), 64'd0);
      chk("t4_flush_addr", 64'(o_mem_address), 64'h100);
      chk("t4_flush_valid", 64'(o_valid), 64'd0);
      step();
      chk("t4_refetch_strobe", 64'(o_mem_read_enable), 64'd1);
      chk("t4_refetch_addr", 64'(o_mem_address), 64'h100);
      i_run = 1'b0;
      step();
      step();
      chk("t4_count", 64'(delivered), 64'd8);

      // Redirect together with a HOLD transfer
      expect_fetch(32'h104); expect_fetch(32'h200);
      i_run = 1'b1;
      step();
      step();
      chk("t5_hold_pc", 64'(o_pc), 64'h104);
      i_redirect = 1'b1; i_redirect_pc = 32'h200;
      step();
      i_redirect = 1'b0;
      chk("t5_after_valid", 64'(o_valid), 64'd0);
      chk("t5_flush_strobe", 64'(o_mem_read_enable), 64'd0);
      chk("t5_count_mid", 64'(delivered), 64'd9);
      step();
      chk("t5_target_addr", 64'(o_mem_address), 64'h200);
      chk("t5_target_strobe", 64'(o_mem_read_enable), 64'd1);
      i_run = 1'b0;
      step();
      step();
      chk("t5_count", 64'(delivered), 64'd10);

      // PC wrap at the top of the address space
      expect_fetch(32'hFFFF_FFFC);
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF; i_run = 1'b1;
      step();
      i_redirect = 1'b0;
      chk("t6_flush_addr", 64'(o_mem_address), 64'hFFFF_FFFC);
      step();
      chk("t6_fetch_strobe", 64'(o_mem_read_enable), 64'd1);
      i_run = 1'b0;
      step();
      step();
      chk("t6_wrap_addr", 64'(o_mem_address), 64'h0);

      // Asynchronous reset during a memory wait
      mem_lat = 5;
      i_run = 1'b1;
      step();
      step();
      chk("t7_wait_strobe", 64'(o_mem_read_enable), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("t7_rst_strobe", 64'(o_mem_read_enable), 64'd0);
      chk("t7_rst_addr", 64'(o_mem_address), 64'h0);
      chk("t7_rst_valid", 64'(o_valid), 64'd0);
      chk("t7_rst_pc", 64'(o_pc), 64'h0);
      chk("t7_rst_ins", 64'(o_instruction), 64'h0);
      mem_lat = 1;
      expect_fetch(32'h0);
      step();
      reset = 1'b1;
      step();
      chk("t7_restart_addr", 64'(o_mem_address), 64'h0);
      chk("t7_restart_strobe", 64'(o_mem_read_enable), 64'd1);
      i_run = 1'b0;
      step();
      step();
      chk("final_count", 64'(delivered), 64'd12);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
